// File: rtl/bm_lpm_concat_packer_if.sv
// Handshake bundle for bm_lpm_concat_packer: input word stream, flush control
// and packed output stream. The master side drives the stream and the slave
// side is the packer.
interface bm_lpm_concat_packer_if #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 32
);
   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             flush_done;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid, out_last, flush_done
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid, out_last, flush_done
   );
endinterface

// File: rtl/bm_lpm_concat_packer.sv
// bm_lpm_concat_packer: packs IN_W-bit words LSB-first into a continuous bit
// stream and emits it as OUT_W-bit words. A flush drains the partial word,
// padded, and tags it with out_last.
// Optional feature: define CONCAT_FILL_ONES_EN to pad flushed partial words
// with 1s instead of 0s.
module bm_lpm_concat_packer #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 32,
   parameter int CNT_W = 6
) (
   input logic                  clock,
   input logic                  reset,
   bm_lpm_concat_packer_if.slave bus
);
   // Accumulator holds one full output word plus one input word.
   localparam int ACC_W = OUT_W + IN_W;
   localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             flush_done_q;

   logic             pop;
   logic             push;
   logic [CNT_W-1:0] pop_amt;
   logic [CNT_W-1:0] base;
   logic [ACC_W-1:0] acc_next;
   logic [CNT_W-1:0] cnt_next;
   logic [OUT_W-1:0] valid_mask;

   // Output view decoded from registered state only.
   assign bus.in_ready   = (state == RUN) && (cnt <= OUT_C);
   assign bus.out_valid  = (state == RUN) ? (cnt >= OUT_C) : (cnt != '0);
   assign bus.out_last   = (state == FLUSH) && (cnt <= OUT_C);
   assign bus.flush_done = flush_done_q;

   assign pop  = bus.out_valid && bus.out_ready;
   assign push = bus.in_valid && bus.in_ready;

   // Mask of bits that hold real data in the low output word; padding elsewhere.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      valid_mask = '0;
      for (int i = 0; i < OUT_W; i++) begin
         valid_mask[i] = (i < int'(cnt));
      end
   end

   // Output word: raw in RUN, padded above cnt in FLUSH.
   always_comb begin
      bus.out_data = acc[OUT_W-1:0];
      if (state == FLUSH) begin
`ifdef CONCAT_FILL_ONES_EN
         bus.out_data = acc[OUT_W-1:0] | ~valid_mask;
`else
         bus.out_data = acc[OUT_W-1:0] & valid_mask;
`endif
      end
   end

   // Next accumulator/count: pop shifts out a word, push lands just above what remains.
   always_comb begin
      pop_amt  = '0;
      acc_next = acc;
      if (pop) begin
         pop_amt  = (cnt >= OUT_C) ? OUT_C : cnt;
         acc_next = acc >> OUT_W;
      end
      base     = cnt - pop_amt;
      cnt_next = base;
      if (push) begin
         // Bits above cnt are always zero, so OR-ing the new word in is safe.
         acc_next = acc_next | ({{(ACC_W-IN_W){1'b0}}, bus.in_data} << base);
         cnt_next = base + IN_C;
      end
   end

   // Datapath registers and RUN/FLUSH control with flush_done pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc          <= '0;
         cnt          <= '0;
         state        <= RUN;
         flush_done_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         acc          <= acc_next;
         cnt          <= cnt_next;
         flush_done_q <= 1'b0;
         case (state)
            RUN: begin
               if (bus.flush) state <= FLUSH;
            end
            FLUSH: begin
               if ((cnt == '0) || (pop && bus.out_last)) begin
                  state        <= RUN;
                  flush_done_q <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_bm_lpm_concat_packer.sv
// Self-checking bench for bm_lpm_concat_packer: a table of push/flush vectors
// plus hand-written sequences for back-pressure, empty flush, async reset and
// a randomly stalled stream.
module tb_bm_lpm_concat_packer;
   localparam int IN_W  = 24;
   localparam int OUT_W = 32;

   typedef struct {
      logic [IN_W-1:0]  w0;
      logic [IN_W-1:0]  w1;
      int               n;          // number of words pushed before flush
      logic [OUT_W-1:0] exp0;       // first output word (zero-padded form)
      logic             last0;
      logic [OUT_W-1:0] exp1;       // second output word when n==2
      int               bits_last;  // valid bits in the final (flushed) word
   } vec_t;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             last;
   } out_t;

   logic clock;
   logic reset;
   bm_lpm_concat_packer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   bm_lpm_concat_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(6)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int   tests_run = 0;
   int   tests_failed = 0;
   int   fd_cnt = 0;
   out_t q[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record every output handshake and every flush_done cycle.
   always @(negedge clock) begin
      if (!reset && bus.out_valid && bus.out_ready) q.push_back('{bus.out_data, bus.out_last});
      if (!reset && bus.flush_done) fd_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected flushed word: data below 'bits', pad above.
   function automatic logic [OUT_W-1:0] padded(input logic [OUT_W-1:0] d, input int bits);
      logic [OUT_W-1:0] r;
      r = d;
      for (int i = 0; i < OUT_W; i++) begin
         if (i >= bits) begin
`ifdef CONCAT_FILL_ONES_EN
            r[i] = 1'b1;
`else
            r[i] = 1'b0;
`endif
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [IN_W-1:0] w);
      int guard;
      guard = 0;
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && guard < 200) begin
         tick();
         guard++;
      end
      if (guard >= 200) check("push_timeout", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Flush, wait for flush_done, and confirm it pulsed exactly once.
   task automatic do_flush();
      int fd0;
      int guard;
      fd0 = fd_cnt;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("in_ready_low_in_flush", 64'(bus.in_ready), 64'd0);
      guard = 0;
      while (fd_cnt == fd0 && guard < 50) begin
         tick();
         guard++;
      end
      check("flush_done_seen", 64'(fd_cnt != fd0), 64'd1);
      tick();
      tick();
      tick();
      check("flush_done_one_cycle", 64'(fd_cnt - fd0), 64'd1);
      check("in_ready_after_flush", 64'(bus.in_ready), 64'd1);
   endtask

   vec_t vecs[6];
   logic [IN_W*100-1:0] stream;
   logic [IN_W-1:0]     rw;

   initial begin
      vecs[0] = '{24'hABCDEF, 24'h000000, 1, 32'h00ABCDEF, 1'b1, 32'h0, 24};
      vecs[1] = '{24'hFFFFFF, 24'h000000, 1, 32'h00FFFFFF, 1'b1, 32'h0, 24};
      vecs[2] = '{24'h123456, 24'h789ABC, 2, 32'hBC123456, 1'b0, 32'h0000789A, 16};
      vecs[3] = '{24'hFFFFFF, 24'h000001, 2, 32'h01FFFFFF, 1'b0, 32'h00000000, 16};
      vecs[4] = '{24'h000000, 24'h000000, 1, 32'h00000000, 1'b1, 32'h0, 24};
      vecs[5] = '{24'h800001, 24'h800000, 2, 32'h00800001, 1'b0, 32'h00008000, 16};

      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      #2;
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_out_last",  64'(bus.out_last),  64'd0);
      check("reset_out_data",  64'(bus.out_data),  64'd0);
      check("reset_in_ready",  64'(bus.in_ready),  64'd1);
      check("reset_flush_done", 64'(bus.flush_done), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      tick();

      // Back-to-back pushes with no stalls.
      q.delete();
      begin
         int fd0;
         fd0 = fd_cnt;
         push(24'h000001);
         push(24'h000002);
         push(24'h000003);
         push(24'h000004);
         for (int i = 0; i < 4; i++) tick();
         check("t1_count", 64'(q.size()), 64'd3);
         if (q.size() == 3) begin
            check("t1_w0", 64'(q[0].data), 64'h02000001);
            check("t1_w1", 64'(q[1].data), 64'h00030000);
            check("t1_w2", 64'(q[2].data), 64'h00000400);
            check("t1_last", 64'({q[0].last, q[1].last, q[2].last}), 64'd0);
         end
         check("t1_no_flush_done", 64'(fd_cnt - fd0), 64'd0);
      end

      // Empty flush right after: cnt must be 0, so nothing comes out.
      q.delete();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("t4_no_valid_c1", 64'(bus.out_valid), 64'd0);
      check("t4_in_ready_c1", 64'(bus.in_ready), 64'd0);
      check("t4_fd_c1", 64'(bus.flush_done), 64'd0);
      tick();
      check("t4_fd_c2", 64'(bus.flush_done), 64'd1);
      check("t4_no_valid_c2", 64'(bus.out_valid), 64'd0);
      tick();
      check("t4_fd_c3", 64'(bus.flush_done), 64'd0);
      check("t4_in_ready_c3", 64'(bus.in_ready), 64'd1);
      check("t4_no_output", 64'(q.size()), 64'd0);

      // Table of push-then-flush vectors.
      for (int v = 0; v < 6; v++) begin
         q.delete();
         push(vecs[v].w0);
         if (vecs[v].n == 2) push(vecs[v].w1);
         do_flush();
         check($sformatf("vec%0d_count", v), 64'(q.size()), 64'(vecs[v].n));
         if (q.size() == vecs[v].n) begin
            if (vecs[v].n == 1) begin
               check($sformatf("vec%0d_w0", v), 64'(q[0].data), 64'(padded(vecs[v].exp0, vecs[v].bits_last)));
               check($sformatf("vec%0d_last0", v), 64'(q[0].last), 64'd1);
            end else begin
               check($sformatf("vec%0d_w0", v), 64'(q[0].data), 64'(vecs[v].exp0));
               check($sformatf("vec%0d_last0", v), 64'(q[0].last), 64'(vecs[v].last0));
               check($sformatf("vec%0d_w1", v), 64'(q[1].data), 64'(padded(vecs[v].exp1, vecs[v].bits_last)));
               check($sformatf("vec%0d_last1", v), 64'(q[1].last), 64'd1);
            end
         end
      end

      // Back-pressure: output held stable, input held off.
      q.delete();
      bus.out_ready = 1'b0;
      push(24'h111111);
      push(24'h222222);
      bus.in_data  = 24'h333333;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t3_in_ready_low%0d", i), 64'(bus.in_ready), 64'd0);
         check($sformatf("t3_valid_hold%0d", i), 64'(bus.out_valid), 64'd1);
         check($sformatf("t3_data_hold%0d", i), 64'(bus.out_data), 64'h22111111);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("t3_pop_count", 64'(q.size()), 64'd1);
      do_flush();
      check("t3_total", 64'(q.size()), 64'd2);
      if (q.size() == 2) begin
         check("t3_w0", 64'(q[0].data), 64'h22111111);
         check("t3_w0_last", 64'(q[0].last), 64'd0);
         check("t3_w1", 64'(q[1].data), 64'(padded(32'h00002222, 16)));
         check("t3_w1_last", 64'(q[1].last), 64'd1);
      end

      // Asynchronous reset mid-stream discards buffered bits.
      q.delete();
      push(24'h000001);
      push(24'h000002);
      #3;
      reset = 1'b1;
      #1;
      check("t5_valid_after_rst", 64'(bus.out_valid), 64'd0);
      check("t5_in_ready_after_rst", 64'(bus.in_ready), 64'd1);
      @(negedge clock);
      reset = 1'b0;
      tick();
      check("t5_no_output", 64'(q.size()), 64'd0);
      push(24'h000005);
      do_flush();
      check("t5_count", 64'(q.size()), 64'd1);
      if (q.size() == 1) begin
         check("t5_w0", 64'(q[0].data), 64'(padded(32'h00000005, 24)));
         check("t5_last", 64'(q[0].last), 64'd1);
      end

      // Random output stalls over 100 words: bitstream must be preserved.
      q.delete();
      begin
         int i;
         int guard;
         logic acc_now;
         i = 0;
         guard = 0;
         while (i < 100 && guard < 5000) begin
            rw = IN_W'($urandom);
            stream[i*IN_W +: IN_W] = rw;
            bus.in_data  = rw;
            bus.in_valid = 1'b1;
            acc_now = 1'b0;
            while (!acc_now && guard < 5000) begin
               bus.out_ready = ($urandom_range(0, 9) >= 3);
               acc_now = bus.in_ready;
               tick();
               guard++;
            end
            i++;
         end
         bus.in_valid = 1'b0;
         while (q.size() < 75 && guard < 5000) begin
            bus.out_ready = ($urandom_range(0, 9) >= 3);
            tick();
            guard++;
         end
         bus.out_ready = 1'b1;
         for (int k = 0; k < 4; k++) tick();
         check("t6_word_count", 64'(q.size()), 64'd75);
         if (q.size() == 75) begin
            for (int k = 0; k < 75; k++) begin
               check($sformatf("t6_w%0d", k), 64'({q[k].last, q[k].data}),
                     64'({1'b0, stream[k*OUT_W +: OUT_W]}));
            end
         end
         check("t6_drained", 64'(bus.out_valid), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/bm_lpm_concat_packer.md
Name: bm_lpm_concat_packer

Overview:
Downstream consumer of the concatenation stage's output. It takes a stream of IN_W-bit concatenated words and packs them LSB-first into a continuous bit stream. The stream is emitted as OUT_W-bit words over a valid/ready handshake. A flush request drains any partial word, zero-padded, and marks it as last. The block is a micro-benchmark stage exercising shifts, variable-offset concatenation, counters and a small FSM.

Parameters:
IN_W, 24, input word width; must satisfy 1 <= IN_W <= OUT_W
OUT_W, 32, output word width
ACC_W, OUT_W+IN_W, accumulator width (derived; not to be overridden)
CNT_W, 6, width of fill counter; must hold ACC_W

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  IN_W  input word; bit 0 is packed first
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
flush  input  1  request to drain the partial word; sampled only when state==RUN
out_data  output  OUT_W  packed output word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  qualifies out_data as final word of a flush
flush_done  output  1  one-cycle pulse when a flush completes

Behaviour:
- State: acc[ACC_W-1:0], cnt (valid bits in acc, 0..ACC_W), FSM {RUN, FLUSH}, flush_done register.
- Reset (async, active-high): acc=0, cnt=0, state=RUN, flush_done=0. Resulting outputs: out_valid=0, out_last=0, out_data=0, in_ready=1. Reset mid-stream discards all buffered bits, with no output.
- in_ready = (state==RUN) && (cnt <= OUT_W). It is driven from registers only and has no combinational dependence on out_ready.
- Output handshake (pop) = out_valid && out_ready. Input handshake (push) = in_valid && in_ready.
- RUN state:
  - out_valid = (cnt >= OUT_W).
  - out_last = 0.
  - out_data = acc[OUT_W-1:0].
- FLUSH state:
  - out_valid = (cnt != 0).
  - out_last = (cnt <= OUT_W).
  - out_data = acc[OUT_W-1:0], with bits at positions >= cnt forced to pad value 0.
- On pop: acc shifts right by OUT_W; cnt -= min(cnt, OUT_W).
- On push: in_data is written at acc[base +: IN_W], where base = cnt minus any same-cycle pop amount; cnt += IN_W.
- Simultaneous push and pop in one cycle are legal. Next cnt = cnt - popped + IN_W.
- Bits of acc above cnt are kept at 0.
- Latency: a word becomes visible on out_data the cycle after the push that makes cnt >= OUT_W.
- RUN -> FLUSH: on any cycle with flush=1. A push in that same cycle is accepted first and is included in the flush.
- FLUSH with cnt==0 on entry: no output; return to RUN next cycle and pulse flush_done.
- FLUSH -> RUN: after the pop with out_last=1; cnt becomes 0 and flush_done=1 for exactly the following cycle.
- While in FLUSH: in_ready=0 and flush is ignored.
- out_data and out_valid are held stable while out_valid && !out_ready.

Optional Feature:
Macro CONCAT_FILL_ONES_EN.
- Defined: padding bits of a partial flushed word are 1.
- Undefined: padding bits are 0.
- All other behaviour is identical in both cases.

Test Plan:
1. Defaults, out_ready=1; push 0x000001, 0x000002, 0x000003, 0x000004 back-to-back -> out_data 0x02000001, 0x00030000, 0x00000400 with out_last=0; cnt ends at 0; no flush_done.
2. Push 0xABCDEF, then pulse flush -> single word 0x00ABCDEF with out_last=1 (0xFFABCDEF with CONCAT_FILL_ONES_EN); flush_done high one cycle after the pop; in_ready=0 during FLUSH.
3. out_ready=0; push 0x111111 and 0x222222 -> in_ready drops after the second push (cnt=48); third input is held off; out_data=0x22111111 is stable with out_valid=1 until out_ready rises; a subsequent flush emits 0x00002222 with out_last=1.
4. Pulse flush with cnt==0 -> no out_valid; flush_done pulses on the second cycle; in_ready returns to 1.
5. Two pushes, then assert reset asynchronously mid-clock -> out_valid=0, in_ready=1 immediately; a following push 0x000005 then flush yields 0x00000005 only.
6. Steady stream with random out_ready stalls (~30% low) over 100 words -> output bitstream equals the input bitstream concatenated LSB-first, with no loss or duplication.
